seq_divider16: RTL

- Multi-cycle 16-bit integer divider, the inverse arithmetic counterpart of the team's 16-bit Brent-Kung adder.
- Uses a restoring algorithm: one quotient bit per clock through a prefix-tree subtractor.
- Sits beside the ALU/LSU datapath and serves M-extension-style DIV/REM requests.
- Valid/ready handshake on both the request and response sides.

---
 rtl/div_pkg.sv | 19 +
 rtl/bk_sub17.sv | 44 ++++
 rtl/seq_divider16.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the seq_divider16 restoring divider.
// The FIX state only exists when SEQ_DIV_SIGNED_EN is defined.
package div_pkg;

    localparam int          WIDTH_C  = 16;
    localparam logic [15:0] DBZ_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    function automatic logic [15:0] neg16(input logic [15:0] x);
        return ~x + 16'd1;
    endfunction

endpackage

// File: rtl/bk_sub17.sv
// 17-bit Brent-Kung prefix subtractor: diff = a + ~b + 1, borrow = no carry out.
module bk_sub17 (
    input  logic [16:0] a,
    input  logic [16:0] b,
    output logic [16:0] diff,
    output logic        borrow
);

    logic [16:0] gen;
    logic [16:0] prop;
    logic [16:0] grp_gen;
    logic [16:0] carry_in;

    // Up-sweep builds spans at 2^k-1, down-sweep fills in the remaining prefixes.
    function automatic logic [16:0] bk_prefix(input logic [16:0] g_in, input logic [16:0] p_in);
        logic [16:0] gg;
        logic [16:0] pp;
        gg = g_in;
        pp = p_in;
        for (int d = 1; d < 17; d = d * 2) begin
            for (int i = 2 * d - 1; i < 17; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        for (int d = 8; d > 0; d = d / 2) begin
            for (int i = 3 * d - 1; i < 17; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        return gg;
    endfunction

    assign gen  = a & ~b;
    assign prop = a ^ ~b;

    // The +1 carry-in is folded into bit 0 so the tree needs no extra level.
    assign grp_gen  = bk_prefix({gen[16:1], gen[0] | prop[0]}, prop);
    assign carry_in = {grp_gen[15:0], 1'b1};
    assign diff     = prop ^ carry_in;
    assign borrow   = ~grp_gen[16];

endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle restoring divider, one quotient bit per clock through bk_sub17.
// Define SEQ_DIV_SIGNED_EN to add the is_signed port and the FIX state.
module seq_divider16
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_C,
    parameter int CNT_W = 5
) (
`ifdef SEQ_DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             dbz_out_q, dbz_out_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
`ifdef SEQ_DIV_SIGNED_EN
    logic             sgn_q, sgn_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
`endif

    logic [16:0] sub_diff;
    logic        sub_borrow;
    logic        sub_unused;

    bk_sub17 u_sub (
        .a      ({p_q, q_q[WIDTH-1]}),
        .b      ({1'b0, dvsr_q}),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    // The kept remainder is always below the divisor, so bit 16 is never needed.
    assign sub_unused = sub_diff[16];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        q_d         = q_q;
        dvsr_d      = dvsr_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dbz_d       = dbz_q;
        dbz_out_d   = dbz_out_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef SEQ_DIV_SIGNED_EN
        sgn_d       = sgn_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = S_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    p_d        = '0;
                    dbz_d      = (divisor == '0);
                    // Divide-by-zero takes one pass through RUN with no iterations.
                    cnt_d      = (divisor == '0) ? '0 : CNT_W'(WIDTH);
                    q_d        = dividend;
                    dvsr_d     = divisor;
`ifdef SEQ_DIV_SIGNED_EN
                    sgn_d      = is_signed;
                    neg_quot_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d  = is_signed && dividend[WIDTH-1];
                    if (is_signed && divisor != '0) begin
                        q_d    = dividend[WIDTH-1] ? neg16(dividend) : dividend;
                        dvsr_d = divisor[WIDTH-1] ? neg16(divisor) : divisor;
                    end
`endif
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    p_d   = sub_borrow ? {p_q[WIDTH-2:0], q_q[WIDTH-1]} : sub_diff[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], ~sub_borrow};
                end else if (dbz_q) begin
                    state_d     = S_DONE;
                    quot_d      = DBZ_QUOT;
                    rem_d       = q_q;
                    dbz_out_d   = 1'b1;
                    out_valid_d = 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
                end else if (sgn_q) begin
                    state_d     = S_FIX;
`endif
                end else begin
                    state_d     = S_DONE;
                    quot_d      = q_q;
                    rem_d       = p_q;
                    dbz_out_d   = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
`ifdef SEQ_DIV_SIGNED_EN
            S_FIX: begin
                state_d     = S_DONE;
                quot_d      = neg_quot_q ? neg16(q_q) : q_q;
                rem_d       = neg_rem_q ? neg16(p_q) : p_q;
                dbz_out_d   = 1'b0;
                out_valid_d = 1'b1;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            dvsr_q      <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            dbz_out_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            sgn_q       <= 1'b0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            q_q         <= q_d;
            dvsr_q      <= dvsr_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
            dbz_out_q   <= dbz_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SEQ_DIV_SIGNED_EN
            sgn_q       <= sgn_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_out_q;
    assign busy        = busy_q;

endmodule
